id_ex_stage: RTL and testbench

//  Decode-to-execute pipeline register for the 32-bit datapath. Sits directly downstream of the register file.

---
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with MEM/WB operand bypass, load-use
// stall detection and one-ahead EX forwarding flags.
module id_ex_stage #(
    parameter int W      = 32,
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [4:0]        id_rd,
    input  logic [W-1:0]      Bus_A,
    input  logic [W-1:0]      Bus_B,
    input  logic [W-1:0]      id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alu_op,
    input  logic [4:0]        mem_rd,
    input  logic              mem_reg_write,
    input  logic [W-1:0]      mem_result,
    input  logic [4:0]        wb_rd,
    input  logic              wb_reg_write,
    input  logic [W-1:0]      wb_result,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [W-1:0]      ex_a,
    output logic [W-1:0]      ex_b,
    output logic [W-1:0]      ex_imm,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic [3:0]        ex_alu_op,
    output logic              ex_fwd_a,
    output logic              ex_fwd_b,
    output logic [SCNT_W-1:0] stall_count
);

    logic              ex_valid_q;
    logic [W-1:0]      ex_a_q, ex_b_q, ex_imm_q;
    logic [4:0]        ex_rd_q;
    logic              ex_reg_write_q, ex_mem_read_q, ex_mem_write_q, ex_alu_src_q;
    logic [3:0]        ex_alu_op_q;
    logic              ex_fwd_a_q, ex_fwd_b_q;
    logic [SCNT_W-1:0] stall_cnt_q;

    // Index 0 is the rs/A source, index 1 the rt/B source.
    logic [1:0][4:0]   src_idx;
    logic [1:0][W-1:0] src_bus;
    logic [1:0][W-1:0] opnd_d;
    logic [1:0]        src_use;
    logic [1:0]        hit_ex;
    logic [1:0]        fwd_d;
    logic              lu;

    assign src_idx = {id_rt, id_rs};
    assign src_bus = {Bus_B, Bus_A};
    assign src_use = {id_use_rt, id_use_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // WB bypass matters because the file only shows the write after the edge.
            assign opnd_d[gi] = (mem_reg_write && mem_rd == src_idx[gi]) ? mem_result :
                                (wb_reg_write  && wb_rd  == src_idx[gi]) ? wb_result  :
                                                                           src_bus[gi];
            assign hit_ex[gi] = src_use[gi] && ex_valid_q && (ex_rd_q == src_idx[gi]);
            assign fwd_d[gi]  = hit_ex[gi] && ex_reg_write_q && !ex_mem_read_q;
        end
    endgenerate

    assign lu       = id_valid && ex_mem_read_q && (|hit_ex);
    assign stall_id = (lu && !flush) || ex_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_a_q         <= '0;
            ex_b_q         <= '0;
            ex_imm_q       <= '0;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_alu_src_q   <= 1'b0;
            ex_alu_op_q    <= '0;
            ex_fwd_a_q     <= 1'b0;
            ex_fwd_b_q     <= 1'b0;
            stall_cnt_q    <= '0;
        end else if (ex_hold) begin
            // Freeze everything; a concurrent flush is retried once hold drops.
        end else if (flush || lu) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            if (!flush && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + SCNT_W'(1);
            end
        end else begin
            ex_valid_q     <= id_valid;
            ex_a_q         <= opnd_d[0];
            ex_b_q         <= opnd_d[1];
            ex_imm_q       <= id_imm;
            ex_rd_q        <= id_rd;
            ex_reg_write_q <= id_valid && id_reg_write;
            ex_mem_read_q  <= id_valid && id_mem_read;
            ex_mem_write_q <= id_valid && id_mem_write;
            ex_alu_src_q   <= id_alu_src;
            ex_alu_op_q    <= id_alu_op;
            ex_fwd_a_q     <= fwd_d[0];
            ex_fwd_b_q     <= fwd_d[1];
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_a         = ex_a_q;
    assign ex_b         = ex_b_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rd        = ex_rd_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_mem_write = ex_mem_write_q;
    assign ex_alu_src   = ex_alu_src_q;
    assign ex_alu_op    = ex_alu_op_q;
    assign ex_fwd_a     = ex_fwd_a_q;
    assign ex_fwd_b     = ex_fwd_b_q;
    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: bypass priority, load-use bubbles,
// one-ahead flags, flush/hold precedence and stall counter saturation.
module tb_id_ex_stage;

    localparam int W      = 32;
    localparam int SCNT_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              id_use_rs, id_use_rt;
    logic [W-1:0]      Bus_A, Bus_B, id_imm;
    logic              id_reg_write, id_mem_read, id_mem_write, id_alu_src;
    logic [3:0]        id_alu_op;
    logic [4:0]        mem_rd, wb_rd;
    logic              mem_reg_write, wb_reg_write;
    logic [W-1:0]      mem_result, wb_result;
    logic              ex_hold, flush;
    logic              stall_id, ex_valid;
    logic [W-1:0]      ex_a, ex_b, ex_imm;
    logic [4:0]        ex_rd;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [3:0]        ex_alu_op;
    logic              ex_fwd_a, ex_fwd_b;
    logic [SCNT_W-1:0] stall_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.W(W), .SCNT_W(SCNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .Bus_A(Bus_A), .Bus_B(Bus_B), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_hold(ex_hold), .flush(flush), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall_count(stall_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_use_rs = 0; id_use_rt = 0;
        Bus_A = 0; Bus_B = 0; id_imm = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_alu_src = 0; id_alu_op = 0;
        mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
        ex_hold = 0; flush = 0;
    endtask

    // Present a plain instruction with no bypass activity.
    task automatic issue(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic [3:0] op);
        id_valid = 1; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_mem_write = 0; id_alu_op = op;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1; id_valid = 1; id_reg_write = 1; Bus_A = 32'hDEAD_BEEF;
        step(); step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
        total++; if (ex_a !== 32'h0) begin bad++; $display("FAIL reset_a got=%h exp=0", ex_a); end
        total++; if (stall_count !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_count); end
        total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL reset_rw got=%0b exp=0", ex_reg_write); end
        reset = 0;
        set_idle();
        step();
        $display("test_reset done");
    endtask

    task automatic test_wb_bypass();
        issue(5'd5, 1, 5'd6, 1, 5'd9, 1, 0, 4'd3);
        Bus_A = 0; Bus_B = 32'h66; id_imm = 32'h10; id_alu_src = 1;
        wb_reg_write = 1; wb_rd = 5'd5; wb_result = 32'h1234;
        step();
        total++; if (ex_a !== 32'h1234) begin bad++; $display("FAIL wb_bypass_a got=%h exp=00001234", ex_a); end
        total++; if (ex_b !== 32'h66) begin bad++; $display("FAIL wb_bus_b got=%h exp=00000066", ex_b); end
        total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_alu_op !== 4'd3)
            begin bad++; $display("FAIL wb_ctrl got=v%0b rd%0d op%0d exp=v1 rd9 op3", ex_valid, ex_rd, ex_alu_op); end
        total++; if (ex_imm !== 32'h10 || ex_alu_src !== 1'b1)
            begin bad++; $display("FAIL wb_imm got=%h/%0b exp=00000010/1", ex_imm, ex_alu_src); end
        set_idle();
        $display("test_wb_bypass done");
    endtask

    task automatic test_mem_priority();
        issue(5'd5, 1, 5'd5, 1, 5'd11, 1, 0, 4'd1);
        mem_reg_write = 1; mem_rd = 5'd5; mem_result = 32'hAAAA;
        wb_reg_write = 1; wb_rd = 5'd5; wb_result = 32'hBBBB;
        step();
        total++; if (ex_a !== 32'hAAAA) begin bad++; $display("FAIL mem_prio_a got=%h exp=0000aaaa", ex_a); end
        total++; if (ex_b !== 32'hAAAA) begin bad++; $display("FAIL mem_prio_b got=%h exp=0000aaaa", ex_b); end
        // WB-only match on B, MEM disabled
        issue(5'd1, 1, 5'd5, 1, 5'd11, 1, 0, 4'd1);
        mem_reg_write = 0; Bus_A = 32'h77; Bus_B = 32'h1;
        step();
        total++; if (ex_b !== 32'hBBBB || ex_a !== 32'h77)
            begin bad++; $display("FAIL wb_b got=%h/%h exp=0000bbbb/00000077", ex_b, ex_a); end
        set_idle();
        $display("test_mem_priority done");
    endtask

    task automatic test_load_use();
        issue(5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 4'd0);
        step();
        issue(5'd3, 1, 5'd4, 1, 5'd8, 1, 0, 4'd2);
        #1;
        total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b exp=1", stall_id); end
        step();
        exp_cnt++;
        total++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0)
            begin bad++; $display("FAIL lu_bubble got=v%0b rw%0b mr%0b exp=000", ex_valid, ex_reg_write, ex_mem_read); end
        total++; if (stall_count !== 4'(exp_cnt)) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_count, exp_cnt); end
        mem_reg_write = 1; mem_rd = 5'd3; mem_result = 32'h5555;
        #1;
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL lu_release got=%0b exp=0", stall_id); end
        step();
        total++; if (ex_valid !== 1'b1 || ex_a !== 32'h5555 || ex_rd !== 5'd8)
            begin bad++; $display("FAIL lu_issue got=v%0b a%h rd%0d exp=v1 a00005555 rd8", ex_valid, ex_a, ex_rd); end
        set_idle();
        $display("test_load_use done");
    endtask

    task automatic test_one_ahead();
        // EX holds add r8 from the previous test
        issue(5'd8, 1, 5'd2, 1, 5'd10, 1, 0, 4'd4);
        #1;
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL oa_nostall got=%0b exp=0", stall_id); end
        step();
        total++; if (ex_fwd_a !== 1'b1 || ex_fwd_b !== 1'b0)
            begin bad++; $display("FAIL oa_fwd_a got=%0b%0b exp=10", ex_fwd_a, ex_fwd_b); end
        issue(5'd10, 0, 5'd10, 1, 5'd12, 1, 0, 4'd4);
        step();
        total++; if (ex_fwd_a !== 1'b0 || ex_fwd_b !== 1'b1)
            begin bad++; $display("FAIL oa_use_gate got=%0b%0b exp=01", ex_fwd_a, ex_fwd_b); end
        // Invalid slot must not carry write/mem controls
        issue(5'd0, 0, 5'd0, 0, 5'd13, 1, 1, 4'd0);
        id_valid = 0; id_mem_write = 1;
        step();
        total++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0)
            begin bad++; $display("FAIL invalid_slot got=v%0b rw%0b mr%0b mw%0b exp=0000", ex_valid, ex_reg_write, ex_mem_read, ex_mem_write); end
        set_idle();
        $display("test_one_ahead done");
    endtask

    task automatic test_flush_hold();
        issue(5'd0, 0, 5'd0, 0, 5'd12, 1, 1, 4'd0);
        step();
        issue(5'd12, 1, 5'd0, 0, 5'd2, 1, 0, 4'd0);
        flush = 1;
        #1;
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b exp=0", stall_id); end
        step();
        total++; if (ex_valid !== 1'b0 || stall_count !== 4'(exp_cnt))
            begin bad++; $display("FAIL flush got=v%0b cnt%0d exp=v0 cnt%0d", ex_valid, stall_count, exp_cnt); end
        set_idle();
        issue(5'd1, 1, 5'd0, 0, 5'd13, 1, 0, 4'd5);
        Bus_A = 32'h1111;
        step();
        ex_hold = 1; flush = 1; id_valid = 0; Bus_A = 32'h2222; id_rd = 5'd14; id_alu_op = 4'd6;
        #1;
        total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL hold_stall got=%0b exp=1", stall_id); end
        step(); step();
        total++; if (ex_a !== 32'h1111 || ex_rd !== 5'd13 || ex_alu_op !== 4'd5 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1)
            begin bad++; $display("FAIL hold_freeze got=a%h rd%0d op%0d v%0b rw%0b exp=a00001111 rd13 op5 v1 rw1", ex_a, ex_rd, ex_alu_op, ex_valid, ex_reg_write); end
        // Hold over a pending load-use keeps the load and the counter frozen
        set_idle();
        issue(5'd0, 0, 5'd0, 0, 5'd15, 1, 1, 4'd0);
        step();
        issue(5'd15, 1, 5'd0, 0, 5'd3, 1, 0, 4'd0);
        ex_hold = 1;
        step();
        total++; if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || stall_count !== 4'(exp_cnt))
            begin bad++; $display("FAIL hold_lu got=v%0b mr%0b cnt%0d exp=v1 mr1 cnt%0d", ex_valid, ex_mem_read, stall_count, exp_cnt); end
        ex_hold = 0;
        step();
        exp_cnt++;
        total++; if (ex_valid !== 1'b0 || stall_count !== 4'(exp_cnt))
            begin bad++; $display("FAIL hold_release got=v%0b cnt%0d exp=v0 cnt%0d", ex_valid, stall_count, exp_cnt); end
        set_idle();
        $display("test_flush_hold done");
    endtask

    task automatic test_back_to_back();
        // Repeated lw + dependent pairs drive the counter into saturation
        for (int i = 0; i < 16; i++) begin
            issue(5'd0, 0, 5'd0, 0, 5'd20, 1, 1, 4'd0);
            step();
            issue(5'd0, 0, 5'd20, 1, 5'd21, 1, 0, 4'd0);
            step();
            if (exp_cnt < 15) exp_cnt++;
            total++; if (stall_count !== 4'(exp_cnt))
                begin bad++; $display("FAIL sat_cnt iter=%0d got=%0d exp=%0d", i, stall_count, exp_cnt); end
            $display("pair %0d stall_count=%0d", i, stall_count);
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_wb_bypass();
        test_mem_priority();
        test_load_use();
        test_one_ahead();
        test_flush_hold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
